config_delay_core: RTL and testbench

- Parametrised successor to the fixed two-register dummy core.
- Holds NUM_REGS configurable registers with a registered read port and a read-only status counter.
- Carries 16b and 1b data through a configurable-delay pipeline of 0..MAX_DELAY stages, with a stall input.
- Sits in a tile as a generic core under the standard config bus.

---
 rtl/config_core_pkg.sv | 20 ++
 rtl/config_delay_line.sv | 35 +++
 rtl/config_delay_core.sv | 118 +++++++++++
 tb/tb_config_delay_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/config_core_pkg.sv
// Shared types and helpers for the configurable-delay core and its delay line.
package config_core_pkg;

    localparam int PIPE_EN_BIT = 16;

    typedef struct packed {
        logic        b1;
        logic [15:0] b16;
    } data_word_t;

    function automatic int delay_bits(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // The status (event counter) register sits directly above the R/W registers.
    function automatic int status_offset(input int num_regs);
        return num_regs;
    endfunction

endpackage

// File: rtl/config_delay_line.sv
// Stallable shift pipeline of MAX_DELAY stages with a selectable output tap.
module config_delay_line
    import config_core_pkg::*;
#(
    parameter int MAX_DELAY  = 7,
    parameter int DELAY_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_stall,
    input  logic [DELAY_BITS-1:0] i_eff_delay,
    input  data_word_t            i_data,
    output data_word_t            o_data
);

    data_word_t r_stage [MAX_DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DELAY; i++) r_stage[i] <= '0;
        end else if (!i_stall) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < MAX_DELAY; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    // Tap 0 is a combinational bypass; tap N reads stage N-1. Taps switch without flushing.
    always_comb begin
        o_data = i_data;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (int'(i_eff_delay) == i + 1) o_data = r_stage[i];
        end
    end

endmodule

// File: rtl/config_delay_core.sv
// Generic tile core: config register file with registered read port, rising-edge
// event counter on data_in_1b, and a configurable-delay data pipeline.
module config_delay_core
    import config_core_pkg::*;
#(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int CFG_WIDTH  = 32,
    parameter int MAX_DELAY  = 7,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] config_config_addr,
    input  logic [CFG_WIDTH-1:0]  config_config_data,
    input  logic                  config_read,
    input  logic                  config_write,
    input  logic                  stall,
    input  logic [15:0]           data_in_16b,
    input  logic                  data_in_1b,
    output logic [15:0]           data_out_16b,
    output logic                  data_out_1b,
    output logic [CFG_WIDTH-1:0]  read_config_data,
    output logic                  read_config_valid
);

    localparam int                    DB          = delay_bits(MAX_DELAY);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(status_offset(NUM_REGS));
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = '1;
    localparam logic [DB-1:0]         DELAY_CAP   = DB'(MAX_DELAY);

    logic [CFG_WIDTH-1:0] r_regs [NUM_REGS];
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_prev;
    logic [CFG_WIDTH-1:0] r_rd_data;
    logic                 r_rd_valid;

    logic [CFG_WIDTH-1:0] w_rd_mux;
    logic [DB-1:0]        w_delay;
    logic                 w_pipe_en;
    logic [DB-1:0]        w_eff_delay;
    logic                 w_status_clr;
    logic                 w_rise;
    data_word_t           w_din;
    data_word_t           w_dout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (config_write) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (config_config_addr == ADDR_WIDTH'(i)) r_regs[i] <= config_config_data;
            end
        end
    end

    // Read mux sees pre-write register and pre-clear counter values.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (config_config_addr == ADDR_WIDTH'(i)) w_rd_mux = r_regs[i];
        end
        if (config_config_addr == STATUS_ADDR) w_rd_mux = CFG_WIDTH'(r_cnt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= config_read;
            if (config_read) r_rd_data <= w_rd_mux;
        end
    end

    assign w_status_clr = config_write && (config_config_addr == STATUS_ADDR);
    assign w_rise       = !stall && data_in_1b && !r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_prev <= 1'b0;
        end else begin
            if (w_status_clr)                  r_cnt <= '0;
            else if (w_rise && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            if (!stall) r_prev <= data_in_1b;
        end
    end

    assign w_delay   = r_regs[0][DB-1:0];
    assign w_pipe_en = r_regs[0][PIPE_EN_BIT];

    always_comb begin
        w_eff_delay = '0;
        if (w_pipe_en) w_eff_delay = (w_delay > DELAY_CAP) ? DELAY_CAP : w_delay;
    end

    assign w_din.b1  = data_in_1b;
    assign w_din.b16 = data_in_16b;

    config_delay_line #(
        .MAX_DELAY  (MAX_DELAY),
        .DELAY_BITS (DB)
    ) u_delay_line (
        .clk         (clk),
        .rst_n       (reset),
        .i_stall     (stall),
        .i_eff_delay (w_eff_delay),
        .i_data      (w_din),
        .o_data      (w_dout)
    );

    assign data_out_16b      = w_dout.b16;
    assign data_out_1b       = w_dout.b1;
    assign read_config_data  = r_rd_data;
    assign read_config_valid = r_rd_valid;

endmodule

// File: tb/tb_config_delay_core.sv
// Directed + random bench for config_delay_core against a history-queue reference model.
module tb_config_delay_core;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int CW = 32;
    localparam int MD = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic [CW-1:0] wdata;
    logic          rd, wr, stall;
    logic [15:0]   d16;
    logic          d1;

    logic [15:0]   o16, o16b;
    logic          o1, o1b;
    logic [CW-1:0] rdat, rdat2;
    logic          vld, vld2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    config_delay_core #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .CFG_WIDTH(CW), .MAX_DELAY(MD), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .config_config_addr(addr), .config_config_data(wdata),
        .config_read(rd), .config_write(wr), .stall(stall), .data_in_16b(d16), .data_in_1b(d1),
        .data_out_16b(o16), .data_out_1b(o1), .read_config_data(rdat), .read_config_valid(vld));

    config_delay_core #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .CFG_WIDTH(CW), .MAX_DELAY(MD), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .config_config_addr(addr), .config_config_data(wdata),
        .config_read(rd), .config_write(wr), .stall(stall), .data_in_16b(d16), .data_in_1b(d1),
        .data_out_16b(o16b), .data_out_1b(o1b), .read_config_data(rdat2), .read_config_valid(vld2));

    // Reference model: accepted samples kept as a history; delay N shows the Nth newest.
    logic [CW-1:0] m_regs [NR];
    logic [16:0]   hist [$];
    int            m_cnt;
    logic          m_prev;
    logic          m_vld;
    logic [CW-1:0] m_rdat, m_rdat2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat(input int c, input int mx);
        return (c > mx) ? CW'(mx) : CW'(c);
    endfunction

    function automatic int m_eff();
        int dl;
        if (!m_regs[0][16]) return 0;
        dl = int'(m_regs[0][2:0]);
        return (dl > MD) ? MD : dl;
    endfunction

    function automatic logic [16:0] m_out();
        int e;
        e = m_eff();
        if (e == 0) return {d1, d16};
        if (hist.size() < e) return '0;
        return hist[hist.size() - e];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        hist.delete();
        m_cnt = 0; m_prev = 0; m_vld = 0; m_rdat = '0; m_rdat2 = '0;
    endtask

    task automatic m_edge();
        int a;
        a = int'(addr);
        if (rd) begin
            m_vld = 1;
            if (a < NR) begin m_rdat = m_regs[a]; m_rdat2 = m_regs[a]; end
            else if (a == NR) begin m_rdat = sat(m_cnt, 65535); m_rdat2 = sat(m_cnt, 15); end
            else begin m_rdat = '0; m_rdat2 = '0; end
        end else m_vld = 0;
        if (wr && a == NR) m_cnt = 0;
        else if (!stall && d1 && !m_prev) m_cnt++;
        if (!stall) m_prev = d1;
        if (wr && a < NR) m_regs[a] = wdata;
        if (!stall) begin
            hist.push_back({d1, d16});
            if (hist.size() > MD) void'(hist.pop_front());
        end
    endtask

    task automatic cyc();
        logic [16:0] e;
        @(negedge clk);
        e = m_out();
        chk("d16", 32'(o16), 32'(e[15:0]));
        chk("d1", 32'(o1), 32'(e[16]));
        chk("d16_c4", 32'(o16b), 32'(e[15:0]));
        chk("vld", 32'(vld), 32'(m_vld));
        chk("rdat", rdat, m_rdat);
        chk("vld_c4", 32'(vld2), 32'(m_vld));
        chk("rdat_c4", rdat2, m_rdat2);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic wr_reg(input int a, input logic [CW-1:0] v);
        wr = 1; addr = AW'(a); wdata = v;
        cyc();
        wr = 0;
    endtask

    task automatic rd_reg(input int a);
        rd = 1; addr = AW'(a);
        cyc();
        rd = 0;
        cyc();
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            d16 = d16 + 16'd1;
            d1 = 1'($urandom);
            cyc();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_d16"}, 32'(o16), 0);
        chk({tag, "_d1"}, 32'(o1), 0);
        chk({tag, "_rdat"}, rdat, 0);
        chk({tag, "_vld"}, 32'(vld), 0);
        chk({tag, "_rdat_c4"}, rdat2, 0);
        chk({tag, "_vld_c4"}, 32'(vld2), 0);
    endtask

    initial begin
        reset = 0; addr = '0; wdata = '0; rd = 0; wr = 0; stall = 0; d16 = '0; d1 = 0;
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("por");
        reset = 1;

        // register file
        wr_reg(2, 32'hDEADBEEF);
        rd_reg(2); chk("reg2", rdat, 32'hDEADBEEF);
        rd_reg(4); chk("status0", rdat, 0);
        rd_reg(9); chk("oob", rdat, 0);

        // delay 3 with pipe enabled, then bypass
        wr_reg(0, 32'h0001_0003);
        d16 = 16'h0000;
        stream(8);
        wr_reg(0, 32'h0000_0005);
        stream(4);

        // clamp to MAX_DELAY, stall holds outputs
        wr_reg(0, 32'h0001_000F);
        stream(10);
        stall = 1;
        stream(4);
        stall = 0;
        stream(10);

        // counter: 5 counted edges, 2 stalled edges
        d1 = 0; cyc();
        wr_reg(4, 0);
        for (int i = 0; i < 5; i++) begin d1 = 1; cyc(); d1 = 0; cyc(); end
        stall = 1;
        for (int i = 0; i < 2; i++) begin d1 = 1; cyc(); d1 = 0; cyc(); end
        stall = 0;
        rd_reg(4); chk("cnt5", rdat, 5); chk("cnt5_c4", rdat2, 5);
        for (int i = 0; i < 20; i++) begin d1 = 1; cyc(); d1 = 0; cyc(); end
        rd_reg(4); chk("cnt25", rdat, 25); chk("cnt_sat", rdat2, 15);
        d1 = 1; wr = 1; addr = AW'(4); cyc(); wr = 0; d1 = 0;
        rd_reg(4); chk("clr_wins", rdat, 0); chk("clr_wins_c4", rdat2, 0);

        // read/write collision
        wr_reg(1, 32'h11);
        rd = 1; wr = 1; addr = AW'(1); wdata = 32'h22; cyc(); rd = 0; wr = 0;
        cyc(); chk("coll_old", rdat, 32'h11);
        rd_reg(1); chk("coll_new", rdat, 32'h22);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rd    = ($urandom_range(0, 3) == 0);
            wr    = ($urandom_range(0, 4) == 0);
            addr  = AW'($urandom_range(0, 9));
            wdata = $urandom();
            stall = ($urandom_range(0, 3) == 0);
            d16   = 16'($urandom());
            d1    = 1'($urandom());
            cyc();
        end
        rd = 0; wr = 0; stall = 0;

        // reset mid-operation
        wr_reg(0, 32'h0001_0003);
        stream(6);
        rd = 1; addr = AW'(0); cyc(); rd = 0;
        #3;
        reset = 0; d16 = '0; d1 = 0;
        #1;
        chk_all_zero("rst_mid");
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("rst_hold");
        reset = 1;
        rd_reg(0); chk("rst_reg0", rdat, 0);
        rd_reg(2); chk("rst_reg2", rdat, 0);
        rd_reg(4); chk("rst_cnt", rdat, 0);
        wr_reg(0, 32'h0001_0003);
        stream(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
